// File: rtl/cic_compensator.sv
// Symmetric 7-tap droop-compensation FIR for a CIC decimator output stream.
// One shared multiplier walks the four unique coefficients, then rounds and saturates.
module cic_compensator #(
   parameter int IW    = 10,
   parameter int OW    = 10,
   parameter int CW    = 8,
   parameter int C0    = -2,
   parameter int C1    = 5,
   parameter int C2    = -14,
   parameter int C3    = 54,
   parameter int SHIFT = 5
) (
   input  logic                 i_clk,
   input  logic                 i_reset,
   input  logic                 i_ce,
   input  logic signed [IW-1:0] i_data,
   output logic signed [OW-1:0] o_data,
   output logic                 o_ready,
   output logic                 o_busy,
   output logic                 o_overrun
);

   // Pre-add grows one bit, the product CW more, and four accumulations two more.
   localparam int AW  = IW + CW + 3;
   localparam int RND = 1 << (SHIFT - 1);
   localparam logic signed [AW-1:0] SAT_MAX = AW'((1 << (OW - 1)) - 1);
   localparam logic signed [AW-1:0] SAT_MIN = AW'(-(1 << (OW - 1)));

   typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

   state_t                state, state_nxt;
   logic [1:0]            tap;
   logic signed [IW-1:0]  x [7];
   logic signed [AW-1:0]  acc;
   logic signed [IW:0]    pre;
   logic signed [CW-1:0]  coef;
   logic signed [IW+CW:0] prod;
   logic signed [AW-1:0]  rnd;
   logic signed [OW-1:0]  sat;
   logic                  accept, mac_en, out_en;

   // NOTE: sequential state always uses non-blocking assignments so every
   // register samples pre-edge values regardless of statement order.
   always_ff @(posedge i_clk) begin
      if (i_reset) state <= IDLE;
      else         state <= state_nxt;
   end

   always_comb begin
      // NOTE: every comb output gets a default first so no path infers a latch.
      state_nxt = state;
      case (state)
         IDLE:    if (i_ce) state_nxt = MAC;
         MAC:     if (tap == 2'd3) state_nxt = OUT;
         OUT:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      o_busy = (state != IDLE);
      accept = (state == IDLE) && i_ce;
      mac_en = (state == MAC);
      out_en = (state == OUT);
   end

   // Symmetric pairs share one multiply; the centre tap has no partner.
   always_comb begin
      pre  = '0;
      coef = '0;
      case (tap)
         2'd0: begin pre = (IW+1)'(x[0]) + (IW+1)'(x[6]); coef = CW'(C0); end
         2'd1: begin pre = (IW+1)'(x[1]) + (IW+1)'(x[5]); coef = CW'(C1); end
         2'd2: begin pre = (IW+1)'(x[2]) + (IW+1)'(x[4]); coef = CW'(C2); end
         default: begin pre = (IW+1)'(x[3]); coef = CW'(C3); end
      endcase
   end

   assign prod = pre * coef;

   // Round half up, then clamp to the output range.
   always_comb begin
      rnd = (acc + AW'(RND)) >>> SHIFT;
      sat = OW'(rnd);
      if (rnd > SAT_MAX)      sat = {1'b0, {(OW-1){1'b1}}};
      else if (rnd < SAT_MIN) sat = {1'b1, {(OW-1){1'b0}}};
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         // NOTE: the delay line is reset on purpose so no stale history leaks
         // into the first outputs after reset; this is not a RAM.
         for (int k = 0; k < 7; k++) x[k] <= '0;
         acc       <= '0;
         tap       <= '0;
         o_data    <= '0;
         o_ready   <= 1'b0;
         o_overrun <= 1'b0;
      end else begin
         o_ready <= out_en;
         if (i_ce && !accept) o_overrun <= 1'b1;
         if (accept) begin
            x[0] <= i_data;
            for (int k = 1; k < 7; k++) x[k] <= x[k-1];
            acc <= '0;
            tap <= '0;
         end
         if (mac_en) begin
            acc <= acc + AW'(prod);
            tap <= tap + 2'd1;
         end
         if (out_en) o_data <= sat;
      end
   end

endmodule

// File: tb/tb_cic_compensator.sv
// Self-checking bench for cic_compensator: directed cases plus random samples
// compared against a direct-form 7-tap convolution model.
module tb_cic_compensator;

   logic              i_clk = 1'b0;
   logic              i_reset = 1'b0;
   logic              i_ce = 1'b0;
   logic signed [9:0] i_data = '0;
   logic signed [9:0] o_data;
   logic              o_ready, o_busy, o_overrun;

   int n_vec = 0;
   int n_err = 0;
   int hist [7];
   int h [7] = '{-2, 5, -14, 54, -14, 5, -2};

   cic_compensator dut (
      .i_clk     (i_clk),
      .i_reset   (i_reset),
      .i_ce      (i_ce),
      .i_data    (i_data),
      .o_data    (o_data),
      .o_ready   (o_ready),
      .o_busy    (o_busy),
      .o_overrun (o_overrun)
   );

   always #5 i_clk = ~i_clk;

   task automatic check(input string tag, input int got, input int exp);
      n_vec++;
      if (got != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   function automatic int floor_div(input int n, input int d);
      int q = n / d;
      if ((n % d != 0) && (n < 0)) q = q - 1;
      return q;
   endfunction

   function automatic int model_out();
      int sum = 0;
      int r;
      for (int k = 0; k < 7; k++) sum += h[k] * hist[k];
      r = floor_div(sum + 16, 32);
      if (r > 511)  r = 511;
      if (r < -512) r = -512;
      return r;
   endfunction

   function automatic void model_push(input int d);
      for (int k = 6; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = d;
   endfunction

   function automatic void model_clear();
      for (int k = 0; k < 7; k++) hist[k] = 0;
   endfunction

   // One accepted sample; optionally a second strobe while busy that must be dropped.
   task automatic apply_sample(input int d, input bit extra_ce, output int got);
      int lat = 0;
      int exp;
      int busy_mid = 0;
      @(negedge i_clk);
      i_ce = 1'b1;
      i_data = 10'(d);
      model_push(d);
      exp = model_out();
      @(negedge i_clk);
      if (extra_ce) i_data = 10'($urandom_range(0, 1023));
      else          i_ce = 1'b0;
      do begin
         @(negedge i_clk);
         i_ce = 1'b0;
         lat++;
         if (lat == 2) busy_mid = int'(o_busy);
      end while (!o_ready && lat < 12);
      got = int'(o_data);
      check("latency", lat, 5);
      check("busy_mid", busy_mid, 1);
      check("out_data", got, exp);
      check("busy_done", int'(o_busy), 0);
      @(negedge i_clk);
      check("ready_width", int'(o_ready), 0);
   endtask

   task automatic do_reset(input bit ce_during);
      @(negedge i_clk);
      i_reset = 1'b1;
      i_ce = ce_during;
      i_data = 10'sd100;
      repeat (3) @(negedge i_clk);
      i_reset = 1'b0;
      i_ce = 1'b0;
      model_clear();
   endtask

   task automatic count_ready(input int cycles, output int n);
      n = 0;
      repeat (cycles) begin
         @(negedge i_clk);
         if (o_ready) n++;
      end
   endtask

   initial begin
      int got, n;
      int imp [8] = '{-6, 16, -44, 169, -44, 16, -6, 0};
      model_clear();

      // Reset with a strobe held during it
      do_reset(1'b1);
      check("rst_data", int'(o_data), 0);
      check("rst_ready", int'(o_ready), 0);
      check("rst_busy", int'(o_busy), 0);
      check("rst_overrun", int'(o_overrun), 0);
      count_ready(10, n);
      check("rst_no_ready", n, 0);

      // Impulse response
      for (int i = 0; i < 8; i++) begin
         apply_sample(i == 0 ? 100 : 0, 1'b0, got);
         check("impulse_tap", got, imp[i]);
      end

      // DC gain, both polarities
      for (int i = 0; i < 10; i++) apply_sample(100, 1'b0, got);
      check("dc_pos", got, 100);
      for (int i = 0; i < 10; i++) apply_sample(-100, 1'b0, got);
      check("dc_neg", got, -100);

      // Saturation at both rails
      for (int i = 0; i < 7; i++) apply_sample((i % 2 == 0) ? -511 : 511, 1'b0, got);
      check("sat_pos", got, 511);
      apply_sample(511, 1'b0, got);
      check("sat_neg", got, -512);

      // Overrun: back-to-back strobes from a clean history
      do_reset(1'b0);
      apply_sample(100, 1'b1, got);
      check("ovr_first", got, -6);
      check("ovr_flag", int'(o_overrun), 1);
      for (int i = 0; i < 3; i++) apply_sample(0, 1'b0, got);
      check("ovr_stream", got, 169);
      check("ovr_sticky", int'(o_overrun), 1);
      do_reset(1'b0);
      check("ovr_cleared", int'(o_overrun), 0);

      // Reset two edges after an accept kills the computation and the history
      apply_sample(50, 1'b0, got);
      @(negedge i_clk);
      i_ce = 1'b1;
      i_data = 10'sd200;
      @(negedge i_clk);
      i_ce = 1'b0;
      @(negedge i_clk);
      i_reset = 1'b1;
      @(negedge i_clk);
      i_reset = 1'b0;
      model_clear();
      count_ready(10, n);
      check("midrst_no_ready", n, 0);
      apply_sample(100, 1'b0, got);
      check("midrst_impulse", got, -6);

      // Random samples, with occasional dropped strobes
      for (int i = 0; i < 60; i++) begin
         apply_sample(int'($urandom_range(0, 1023)) - 512, ($urandom_range(0, 7) == 0), got);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
